// File: rtl/relu_layer_sequencer_if.sv
// relu_layer_sequencer_if: input-beat and output-vector handshake bundle for relu_layer_sequencer.
`ifndef N
`define N 16
`endif
interface relu_layer_sequencer_if #(parameter int SIZE = 3);
  logic                      in_valid;
  logic                      in_ready;
  logic [`N-1:0]             in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SIZE-1:0][`N-1:0]   out_data;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/relu_layer_sequencer.sv
// relu_layer_sequencer: collects Size serial words, applies ReLU, presents the vector in parallel.
// Optional ACT_BYPASS_EN adds a bypass port latched on start that stores elements unmodified.
`ifndef N
`define N 16
`endif
module relu_layer_sequencer #(
  parameter  int Size = 3,
  localparam int CW   = $clog2(Size + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
`ifdef ACT_BYPASS_EN
  input  logic                      bypass,
`endif
  relu_layer_sequencer_if.slave     bus,
  output logic                      busy,
  output logic                      done,
  output logic [CW-1:0]             neg_count
);
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [Size-1:0][`N-1:0] vec;
  logic beat, last, lin, go;
  assign go   = state == IDLE && start && !abort;
  assign beat = state == FILL && bus.in_valid && !abort;
  assign last = cnt == CW'(Size - 1);
  assign bus.out_data = vec;
`ifdef ACT_BYPASS_EN
  logic bypass_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bypass_q <= 1'b0;
    else if (go) bypass_q <= bypass;
  assign lin = bypass_q;
`else
  assign lin = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // abort outranks start, beats and the output handshake
  always_comb begin
    nxt = state;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    busy = state != IDLE;
    if (abort) nxt = IDLE;
    else if (state == IDLE) nxt = start ? FILL : IDLE;
    else if (state == FILL) nxt = beat && last ? HOLD : FILL;
    else nxt = bus.out_ready ? IDLE : HOLD;
    bus.in_ready = state == FILL;
    bus.out_valid = state == HOLD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      neg_count <= '0;
      vec <= '0;
      done <= 1'b0;
    end else begin
      done <= state == HOLD && bus.out_ready && !abort;
      if (go) begin
        cnt <= '0;
        neg_count <= '0;
      end else if (beat) begin
        cnt <= cnt + 1'b1;
        neg_count <= neg_count + CW'(bus.in_data[`N-1]);
      end else if (abort || (state == HOLD && bus.out_ready)) cnt <= '0;
      for (int i = 0; i < Size; i++)
        if (beat && cnt == CW'(i)) vec[i] <= bus.in_data[`N-1] && !lin ? '0 : bus.in_data;
    end
endmodule
